// File: rtl/traffic_generator_gmii_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : traffic_generator_gmii_pkg
//  Description : Shared types and constants of the GMII frame-generation
//                engine: transmit state encoding, preamble/SFD bytes,
//                preamble length and maximum frame size, plus a byte-lane
//                selection helper.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package traffic_generator_gmii_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      PREAMBLE = 2'd1,
      DATA     = 2'd2,
      GAP      = 2'd3
   } tx_state_t;

   localparam logic [7:0]  PREAMBLE_BYTE   = 8'h55;
   localparam logic [7:0]  SFD_BYTE        = 8'hD5;
   localparam int unsigned PREAMBLE_LEN    = 8;
   localparam int unsigned MAX_FRAME_BYTES = 1024;

   // Lane 0 is bits [7:0], lane 3 is bits [31:24].
   function automatic logic [7:0] byte_lane(input logic [31:0] word,
                                            input logic [1:0]  lane);
      return word[{lane, 3'b000} +: 8];
   endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_generator_gmii_engine_if.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : traffic_generator_gmii_engine_if
//  Description : Frame-buffer write bus between the CPU register block and
//                the frame-generation engine.
//                  frame_buf_data    : 32-bit word to store
//                  frame_buf_address : word address
//                  frame_buf_wr      : one word written per cycle while high
//                master = register block (drives), slave = engine (receives).
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
interface traffic_generator_gmii_engine_if #(
   parameter int BUF_ADDR_WIDTH = 8
) ();

   logic [31:0]               frame_buf_data;
   logic [BUF_ADDR_WIDTH-1:0] frame_buf_address;
   logic                      frame_buf_wr;

   modport master (output frame_buf_data, output frame_buf_address, output frame_buf_wr);
   modport slave  (input  frame_buf_data, input  frame_buf_address, input  frame_buf_wr);

endinterface
`default_nettype wire

// File: rtl/traffic_generator_gmii_frame_ram.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : traffic_generator_gmii_frame_ram
//  Description : Simple dual-port frame-template RAM, 2^ADDR_WIDTH x 32.
//                  clk     : clock
//                  wr_en   : write enable
//                  wr_addr : write word address
//                  wr_data : write data
//                  rd_addr : read word address
//                  rd_data : registered read data (1-cycle latency)
//                Read-first on an address collision. Contents are not reset.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module traffic_generator_gmii_frame_ram #(
   parameter int ADDR_WIDTH = 8
) (
   input  wire                  clk,
   input  wire                  wr_en,
   input  wire [ADDR_WIDTH-1:0] wr_addr,
   input  wire [31:0]           wr_data,
   input  wire [ADDR_WIDTH-1:0] rd_addr,
   output logic [31:0]          rd_data
);

   logic [31:0] r_mem [0:(2**ADDR_WIDTH)-1];
   logic [31:0] r_rd_data;

   // Both ports in one process: the read samples the old word, giving
   // read-first behaviour on a collision.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         r_mem[wr_addr] <= wr_data;
      end
      r_rd_data <= r_mem[rd_addr];
   end

   assign rd_data = r_rd_data;

endmodule
`default_nettype wire

// File: rtl/traffic_generator_gmii_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : traffic_generator_gmii_engine
//  Description : GMII frame-generation engine. Transmits the buffered frame
//                template with preamble/SFD, inter-frame and inter-burst gaps
//                and an optional total-frame limit.
//  Ports       : clk, resetn (sync, active-low)
//                control_reg[0] run, interframe_gap_reg, interburst_gap_reg,
//                frames_per_burst_reg, total_frames_reg, frame_size_reg
//                frame_buf  : frame-buffer write bus (slave modport)
//                gmii_txd / gmii_tx_en / gmii_tx_er : GMII transmit
//                busy, frames_sent : run status
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module traffic_generator_gmii_engine
   import traffic_generator_gmii_pkg::*;
#(
   parameter int BUF_ADDR_WIDTH = 8,
   parameter int MIN_IFG        = 12
) (
   input  wire         clk,
   input  wire         resetn,
   input  wire  [31:0] control_reg,
   input  wire  [31:0] interframe_gap_reg,
   input  wire  [31:0] interburst_gap_reg,
   input  wire  [31:0] frames_per_burst_reg,
   input  wire  [63:0] total_frames_reg,
   input  wire  [15:0] frame_size_reg,
   traffic_generator_gmii_engine_if.slave frame_buf,
   output logic [7:0]  gmii_txd,
   output logic        gmii_tx_en,
   output logic        gmii_tx_er,
   output logic        busy,
   output logic [63:0] frames_sent
);

   localparam logic [31:0] C_MIN_GAP  = 32'(MIN_IFG);
   localparam logic [10:0] C_MAX_SIZE = 11'(MAX_FRAME_BYTES);

   tx_state_t   r_state, w_state_nxt;
   logic [31:0] r_cnt, w_cnt_nxt;
   logic        r_run_q;
   logic [7:0]  r_txd, w_txd_nxt;
   logic        r_tx_en, w_tx_en_nxt;
   logic        r_tx_er;
   logic        r_busy;
   logic [63:0] r_frames_sent;

   // Run snapshot
   logic [31:0] r_ifg, r_ibg, r_fpb, r_burst_cnt, r_gap_len;
   logic [63:0] r_total;
   logic [10:0] r_frame_size;

   logic        w_start, w_stop, w_last_data;
   logic [31:0] w_cnt_inc, w_cnt_p2, w_size_m1, w_gap_m1;
   logic [BUF_ADDR_WIDTH-1:0] w_rd_addr;
   logic [31:0] w_ram_rd_data;
   logic        w_unused;

   assign w_cnt_inc = r_cnt + 32'd1;
   assign w_cnt_p2  = r_cnt + 32'd2;
   assign w_size_m1 = {21'd0, r_frame_size} - 32'd1;
   assign w_gap_m1  = r_gap_len - 32'd1;

   assign w_start = control_reg[0] && !r_run_q && (r_state == IDLE) &&
                    (frame_size_reg != 16'd0);
   // frames_sent is already incremented by the time GAP ends.
   assign w_stop  = ((r_total != 64'd0) && (r_frames_sent == r_total)) ||
                    !control_reg[0];

   assign w_unused = ^{control_reg[31:1], w_cnt_p2[31:BUF_ADDR_WIDTH+2], w_cnt_p2[1:0]};

   traffic_generator_gmii_frame_ram #(
      .ADDR_WIDTH (BUF_ADDR_WIDTH)
   ) u_frame_ram (
      .clk     (clk),
      .wr_en   (frame_buf.frame_buf_wr),
      .wr_addr (frame_buf.frame_buf_address),
      .wr_data (frame_buf.frame_buf_data),
      .rd_addr (w_rd_addr),
      .rd_data (w_ram_rd_data)
   );

   // Next-state and next-output logic. Outputs are computed for the value
   // that will be on the pins after the coming edge, so r_cnt is always the
   // index of the byte/cycle currently on the pins.
   // RAM pipeline: txd is loaded from rd_data, and rd_data lags the address
   // by one edge, so the address presented now is that of the byte two
   // positions ahead ((cnt+2)>>2). Word 0 is addressed throughout PREAMBLE.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_txd_nxt   = 8'h00;
      w_tx_en_nxt = 1'b0;
      w_last_data = 1'b0;
      w_rd_addr   = '0;

      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt = PREAMBLE;
               w_cnt_nxt   = 32'd0;
               w_txd_nxt   = PREAMBLE_BYTE;
               w_tx_en_nxt = 1'b1;
            end
         end

         PREAMBLE: begin
            w_tx_en_nxt = 1'b1;
            if (r_cnt == 32'(PREAMBLE_LEN - 1)) begin
               w_state_nxt = DATA;
               w_cnt_nxt   = 32'd0;
               w_txd_nxt   = byte_lane(w_ram_rd_data, 2'd0);
            end else begin
               w_cnt_nxt = w_cnt_inc;
               w_txd_nxt = (r_cnt == 32'(PREAMBLE_LEN - 2)) ? SFD_BYTE : PREAMBLE_BYTE;
            end
         end

         DATA: begin
            w_rd_addr = w_cnt_p2[BUF_ADDR_WIDTH+1:2];
            if (r_cnt == w_size_m1) begin
               w_last_data = 1'b1;
               w_state_nxt = GAP;
               w_cnt_nxt   = 32'd0;
            end else begin
               w_cnt_nxt   = w_cnt_inc;
               w_tx_en_nxt = 1'b1;
               w_txd_nxt   = byte_lane(w_ram_rd_data, w_cnt_inc[1:0]);
            end
         end

         GAP: begin
            if (r_cnt == w_gap_m1) begin
               w_cnt_nxt = 32'd0;
               if (w_stop) begin
                  w_state_nxt = IDLE;
               end else begin
                  w_state_nxt = PREAMBLE;
                  w_txd_nxt   = PREAMBLE_BYTE;
                  w_tx_en_nxt = 1'b1;
               end
            end else begin
               w_cnt_nxt = w_cnt_inc;
            end
         end

         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 32'd0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_cnt   <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         r_run_q       <= 1'b0;
         r_txd         <= 8'h00;
         r_tx_en       <= 1'b0;
         r_tx_er       <= 1'b0;
         r_busy        <= 1'b0;
         r_frames_sent <= 64'd0;
         r_ifg         <= C_MIN_GAP;
         r_ibg         <= C_MIN_GAP;
         r_fpb         <= 32'd0;
         r_burst_cnt   <= 32'd0;
         r_gap_len     <= C_MIN_GAP;
         r_total       <= 64'd0;
         r_frame_size  <= 11'd0;
      end else begin
         r_run_q <= control_reg[0];
         r_txd   <= w_txd_nxt;
         r_tx_en <= w_tx_en_nxt;
         r_tx_er <= 1'b0;
         r_busy  <= (w_state_nxt != IDLE);

         if (w_start) begin
            r_ifg        <= (interframe_gap_reg < C_MIN_GAP) ? C_MIN_GAP : interframe_gap_reg;
            r_ibg        <= (interburst_gap_reg < C_MIN_GAP) ? C_MIN_GAP : interburst_gap_reg;
            r_fpb        <= frames_per_burst_reg;
            r_burst_cnt  <= frames_per_burst_reg;
            r_total      <= total_frames_reg;
            r_frame_size <= (frame_size_reg > 16'(C_MAX_SIZE)) ? C_MAX_SIZE : frame_size_reg[10:0];
            r_frames_sent <= 64'd0;
         end else if (w_last_data) begin
            r_frames_sent <= r_frames_sent + 64'd1;
            // Down-counter reaching 1 marks the last frame of a burst, which
            // is equivalent to frames_sent mod frames_per_burst == 0.
            if ((r_fpb != 32'd0) && (r_burst_cnt == 32'd1)) begin
               r_gap_len   <= r_ibg;
               r_burst_cnt <= r_fpb;
            end else begin
               r_gap_len <= r_ifg;
               if (r_fpb != 32'd0) begin
                  r_burst_cnt <= r_burst_cnt - 32'd1;
               end
            end
         end
      end
   end

   assign gmii_txd    = r_txd;
   assign gmii_tx_en  = r_tx_en;
   assign gmii_tx_er  = r_tx_er;
   assign busy        = r_busy;
   assign frames_sent = r_frames_sent;

endmodule
`default_nettype wire

// File: tb/tb_traffic_generator_gmii_engine.sv
`default_nettype none
//------------------------------------------------------------------------------
//  Module      : tb_traffic_generator_gmii_engine
//  Description : Directed self-checking bench for the GMII frame engine.
//                Buffer holds byte k = k mod 256 in every frame position.
//  Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module tb_traffic_generator_gmii_engine;

   logic        clk = 1'b0;
   logic        resetn;
   logic [31:0] control_reg;
   logic [31:0] interframe_gap_reg;
   logic [31:0] interburst_gap_reg;
   logic [31:0] frames_per_burst_reg;
   logic [63:0] total_frames_reg;
   logic [15:0] frame_size_reg;
   logic [7:0]  gmii_txd;
   logic        gmii_tx_en;
   logic        gmii_tx_er;
   logic        busy;
   logic [63:0] frames_sent;

   int n_vec = 0;
   int n_err = 0;
   int cyc   = 0;
   int t_first;

   traffic_generator_gmii_engine_if #(.BUF_ADDR_WIDTH(8)) fb_if ();

   traffic_generator_gmii_engine #(
      .BUF_ADDR_WIDTH (8),
      .MIN_IFG        (12)
   ) dut (
      .clk                  (clk),
      .resetn               (resetn),
      .control_reg          (control_reg),
      .interframe_gap_reg   (interframe_gap_reg),
      .interburst_gap_reg   (interburst_gap_reg),
      .frames_per_burst_reg (frames_per_burst_reg),
      .total_frames_reg     (total_frames_reg),
      .frame_size_reg       (frame_size_reg),
      .frame_buf            (fb_if),
      .gmii_txd             (gmii_txd),
      .gmii_tx_en           (gmii_tx_en),
      .gmii_tx_er           (gmii_tx_er),
      .busy                 (busy),
      .frames_sent          (frames_sent)
   );

   always #4 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Called at the negedge showing the first preamble byte. Returns at the
   // negedge showing the next frame's first byte, or the first idle cycle.
   task automatic get_frame(input int clr_at, output int pre_errs, output int dlen,
                            output int derrs, output int glen, output bit idle_end);
      logic [7:0] exp_b;
      pre_errs = 0; dlen = 0; derrs = 0; glen = 0;
      for (int i = 0; i < 8; i++) begin
         exp_b = (i == 7) ? 8'hD5 : 8'h55;
         if (gmii_tx_en !== 1'b1 || gmii_txd !== exp_b || gmii_tx_er !== 1'b0) pre_errs++;
         @(negedge clk);
      end
      while (gmii_tx_en === 1'b1 && dlen < 2000) begin
         exp_b = dlen[7:0];
         if (gmii_txd !== exp_b || gmii_tx_er !== 1'b0) derrs++;
         dlen++;
         if (dlen == clr_at) control_reg = 32'd0;
         @(negedge clk);
      end
      while (gmii_tx_en !== 1'b1 && busy === 1'b1 && glen < 2000) begin
         glen++;
         @(negedge clk);
      end
      idle_end = (busy === 1'b0);
   endtask

   task automatic frame_vec(input string tag, input int exp_len, input int exp_gap,
                            input bit exp_idle, input int clr_at);
      int pe, dl, de, gl;
      bit ie;
      get_frame(clr_at, pe, dl, de, gl, ie);
      check($sformatf("%s preamble", tag), 64'(pe), 64'd0);
      check($sformatf("%s len", tag), 64'(dl), 64'(exp_len));
      check($sformatf("%s data", tag), 64'(de), 64'd0);
      check($sformatf("%s gap", tag), 64'(gl), 64'(exp_gap));
      check($sformatf("%s idle", tag), 64'(ie), 64'(exp_idle));
   endtask

   task automatic start_run(input string tag);
      control_reg = 32'd0;
      @(negedge clk);
      @(negedge clk);
      control_reg = 32'h0000_0001;
      @(negedge clk);
      check($sformatf("%s start busy", tag), 64'(busy), 64'd1);
      check($sformatf("%s start txd", tag), {55'd0, gmii_tx_en, gmii_txd}, {55'd0, 1'b1, 8'h55});
      t_first = cyc;
   endtask

   task automatic set_regs(input int fsz, input int ifg, input int ibg, input int fpb, input int tot);
      frame_size_reg       = 16'(fsz);
      interframe_gap_reg   = 32'(ifg);
      interburst_gap_reg   = 32'(ibg);
      frames_per_burst_reg = 32'(fpb);
      total_frames_reg     = 64'(tot);
   endtask

   initial begin
      resetn = 1'b0;
      control_reg = 32'd0;
      set_regs(0, 12, 12, 0, 0);
      fb_if.frame_buf_wr      = 1'b0;
      fb_if.frame_buf_address = 8'd0;
      fb_if.frame_buf_data    = 32'd0;
      repeat (3) @(negedge clk);

      check("rst busy", 64'(busy), 64'd0);
      check("rst tx_en", 64'(gmii_tx_en), 64'd0);
      check("rst tx_er", 64'(gmii_tx_er), 64'd0);
      check("rst txd", 64'(gmii_txd), 64'd0);
      check("rst frames_sent", frames_sent, 64'd0);
      resetn = 1'b1;

      // Load word w = {4w+3, 4w+2, 4w+1, 4w} (mod 256 per byte).
      for (int w = 0; w < 256; w++) begin
         logic [7:0] b0;
         b0 = 8'(4 * w);
         fb_if.frame_buf_wr      = 1'b1;
         fb_if.frame_buf_address = 8'(w);
         fb_if.frame_buf_data    = {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0};
         @(negedge clk);
      end
      fb_if.frame_buf_wr = 1'b0;

      // Zero frame size: start ignored.
      set_regs(0, 12, 12, 0, 1);
      control_reg = 32'd1;
      repeat (3) @(negedge clk);
      check("size0 busy", 64'(busy), 64'd0);
      check("size0 tx_en", 64'(gmii_tx_en), 64'd0);

      // 3 frames of 64 bytes, IFG 12: 3 * (8+64+12) = 252 cycles.
      set_regs(64, 12, 12, 0, 3);
      start_run("t1");
      frame_vec("t1 f1", 64, 12, 1'b0, 0);
      frame_vec("t1 f2", 64, 12, 1'b0, 0);
      frame_vec("t1 f3", 64, 12, 1'b1, 0);
      check("t1 period", 64'(cyc - t_first), 64'd252);
      check("t1 frames_sent", frames_sent, 64'd3);

      // Bursts of 2: gaps 12, 100, 12, 100.
      set_regs(60, 12, 100, 2, 4);
      start_run("t2");
      frame_vec("t2 f1", 60, 12, 1'b0, 0);
      frame_vec("t2 f2", 60, 100, 1'b0, 0);
      frame_vec("t2 f3", 60, 12, 1'b0, 0);
      frame_vec("t2 f4", 60, 100, 1'b1, 0);
      check("t2 frames_sent", frames_sent, 64'd4);

      // Clamps: gap 5 -> 12, size 2000 -> 1024.
      set_regs(2000, 5, 5, 0, 2);
      start_run("t3");
      frame_vec("t3 f1", 1024, 12, 1'b0, 0);
      frame_vec("t3 f2", 1024, 12, 1'b1, 0);
      check("t3 frames_sent", frames_sent, 64'd2);

      // Unlimited run, run cleared mid-DATA of frame 7.
      set_regs(64, 12, 12, 0, 0);
      start_run("t4");
      for (int f = 1; f <= 6; f++) frame_vec($sformatf("t4 f%0d", f), 64, 12, 1'b0, 0);
      frame_vec("t4 f7", 64, 12, 1'b1, 10);
      check("t4 frames_sent", frames_sent, 64'd7);

      // Reset mid-frame, then re-run from retained buffer.
      set_regs(64, 12, 12, 0, 0);
      start_run("t5");
      repeat (30) @(negedge clk);
      resetn = 1'b0;
      control_reg = 32'd0;
      @(negedge clk);
      check("t5 rst tx_en", 64'(gmii_tx_en), 64'd0);
      check("t5 rst busy", 64'(busy), 64'd0);
      @(negedge clk);
      resetn = 1'b1;
      set_regs(64, 12, 12, 0, 1);
      start_run("t5b");
      frame_vec("t5b f1", 64, 12, 1'b1, 0);
      check("t5b frames_sent", frames_sent, 64'd1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
